// File: rtl/sd_sector_buffer.sv
// Sector buffer between the SD sector reader and a disk controller: one card read fills a 512x8 RAM.
// Define SD_BUFFER_CACHE_EN to enable the single-entry LBA tag; without it every request goes to the card.
module sd_sector_buffer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] lba,
    input  logic        flush,
    output logic        busy,
    output logic        ack,
    output logic        err,
    input  logic [8:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        sd_rstart,
    output logic [31:0] sd_rsector,
    input  logic        sd_rbusy,
    input  logic        sd_rdone,
    input  logic        sd_outen,
    input  logic [8:0]  sd_outaddr,
    input  logic [7:0]  sd_outbyte
);

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned LBA_W        = 32;
    localparam int unsigned TMO_W        = 32;
    localparam int unsigned SECTOR_BYTES = 512;

`ifdef SD_BUFFER_CACHE_EN
    localparam logic CACHE_EN = 1'b1;
`else
    localparam logic CACHE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAITRDY,
        START,
        FILL,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               busy_d;
    logic               ack_d;
    logic               err_d;
    logic               rstart_d;
    logic [LBA_W-1:0]   rsector_d;
    logic [LBA_W-1:0]   cur_lba;
    logic [LBA_W-1:0]   cur_lba_d;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   byte_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_inc;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_d;
    logic               tmo_hit;
    logic               tag_valid;
    logic               tag_valid_d;
    logic [LBA_W-1:0]   tag_lba;
    logic [LBA_W-1:0]   tag_lba_d;
    logic               hit;

    logic [DATA_W-1:0]  mem [SECTOR_BYTES];

    // Card side writes in every state; client read is registered (read-before-write on collision)
    always_ff @(posedge clk) begin
        if (sd_outen) begin
            mem[sd_outaddr] <= sd_outbyte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // A simultaneous flush wins over the tag, so that request misses
    assign hit          = tag_valid && !flush && (tag_lba == lba);
    assign tmo_hit      = (tmo_cnt >= TIMEOUT_CYCLES);
    assign byte_cnt_inc = (sd_outen && (byte_cnt != CNT_W'(SECTOR_BYTES)))
                          ? byte_cnt + CNT_W'(1) : byte_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rsector_d   = sd_rsector;
        cur_lba_d   = cur_lba;
        byte_cnt_d  = byte_cnt;
        tmo_cnt_d   = tmo_cnt;
        tag_valid_d = tag_valid;
        tag_lba_d   = tag_lba;

        case (state)
            IDLE: begin
                if (req) begin
                    cur_lba_d = lba;
                    if (hit) begin
                        ack_d = 1'b1;
                    end else begin
                        tag_valid_d = 1'b0;
                        state_d     = WAITRDY;
                    end
                end
            end
            WAITRDY: begin
                if (!sd_rbusy) begin
                    state_d    = START;
                    rsector_d  = cur_lba;
                    byte_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            START: begin
                byte_cnt_d = byte_cnt_inc;
                tmo_cnt_d  = tmo_cnt + TMO_W'(1);
                if (tmo_hit) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else if (sd_rbusy) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                byte_cnt_d = byte_cnt_inc;
                tmo_cnt_d  = tmo_cnt + TMO_W'(1);
                if (sd_rdone) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                    if (byte_cnt_inc == CNT_W'(SECTOR_BYTES)) begin
                        if (CACHE_EN) begin
                            tag_valid_d = 1'b1;
                            tag_lba_d   = cur_lba;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sd_rdone || !sd_rbusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            tag_valid_d = 1'b0;
        end

        // busy covers the ack cycle of a card access, but never a hit
        busy_d   = (state_d != IDLE) || (ack_d && (state != IDLE));
        rstart_d = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            ack        <= 1'b0;
            err        <= 1'b0;
            sd_rstart  <= 1'b0;
            sd_rsector <= '0;
            cur_lba    <= '0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            tag_valid  <= 1'b0;
            tag_lba    <= '0;
        end else begin
            busy       <= busy_d;
            ack        <= ack_d;
            err        <= err_d;
            sd_rstart  <= rstart_d;
            sd_rsector <= rsector_d;
            cur_lba    <= cur_lba_d;
            byte_cnt   <= byte_cnt_d;
            tmo_cnt    <= tmo_cnt_d;
            tag_valid  <= tag_valid_d;
            tag_lba    <= tag_lba_d;
        end
    end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: scripted SD reader model with ack and readback scoreboards.
module tb_sd_sector_buffer;

    localparam logic [31:0] TMO = 32'd1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] lba;
    logic        flush;
    logic        busy;
    logic        ack;
    logic        err;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        sd_rstart;
    logic [31:0] sd_rsector;
    logic        sd_rbusy;
    logic        sd_rdone;
    logic        sd_outen;
    logic [8:0]  sd_outaddr;
    logic [7:0]  sd_outbyte;

    int checks = 0;
    int errors = 0;

    logic       exp_ack_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] exp_mem [512];

    sd_sector_buffer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lba        (lba),
        .flush      (flush),
        .busy       (busy),
        .ack        (ack),
        .err        (err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sd_rstart  (sd_rstart),
        .sd_rsector (sd_rsector),
        .sd_rbusy   (sd_rbusy),
        .sd_rdone   (sd_rdone),
        .sd_outen   (sd_outen),
        .sd_outaddr (sd_outaddr),
        .sd_outbyte (sd_outbyte)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue_req(input logic [31:0] l, input logic fl);
        req   = 1'b1;
        lba   = l;
        flush = fl;
        tick();
        req   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic stream(input int n, input logic [7:0] x);
        for (int i = 0; i < n; i++) begin
            sd_outen   = 1'b1;
            sd_outaddr = 9'(i);
            sd_outbyte = 8'(i) ^ x;
            exp_mem[i] = 8'(i) ^ x;
            tick();
        end
        sd_outen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || sd_rstart !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b ack=%b err=%b rstart=%b, required all 0", busy, ack, err, sd_rstart);
        end
        checks++;
        if (sd_rsector !== 32'd0 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: rsector=%0d rd_data=%0h, required 0 and 0", sd_rsector, rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill(input logic [31:0] l, input logic fl, input int n,
                             input logic [7:0] x, input int init);
        int   cnt;
        logic e;
        exp_ack_q.push_back(n != 512);
        sd_rbusy = (init > 0);
        repeat (init) tick();
        issue_req(l, fl);
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL miss_busy lba=%0d: busy=%b ack=%b, required busy=1 ack=0", l, busy, ack);
        end
        checks++;
        if (sd_rstart !== 1'b0) begin
            errors++;
            $display("FAIL rstart_early lba=%0d: rstart=%b at N+1, required 0", l, sd_rstart);
        end
        if (init > 0) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                checks++;
                if (sd_rstart !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL init_wait: rstart=%b busy=%b while reader busy, required 0 and 1", sd_rstart, busy);
                end
            end
            sd_rbusy = 1'b0;
        end
        cnt = 0;
        while (sd_rstart !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (sd_rstart !== 1'b1) begin
            errors++;
            $display("FAIL rstart_wait lba=%0d: rstart=%b after %0d cycles, required 1", l, sd_rstart, cnt);
        end
        checks++;
        if (sd_rsector !== l) begin
            errors++;
            $display("FAIL rsector: got %0d, required %0d", sd_rsector, l);
        end
        tick();
        tick();
        checks++;
        if (sd_rstart !== 1'b1) begin
            errors++;
            $display("FAIL rstart_hold: rstart=%b before reader busy, required 1", sd_rstart);
        end
        sd_rbusy = 1'b1;
        tick();
        checks++;
        if (sd_rstart !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstart_release: rstart=%b busy=%b, required 0 and 1", sd_rstart, busy);
        end
        stream(n, x);
        sd_rdone = 1'b1;
        sd_rbusy = 1'b0;
        tick();
        sd_rdone = 1'b0;
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== 1'b1 || err !== e) begin
            errors++;
            $display("FAIL fill_ack lba=%0d: ack=%b err=%b, required ack=1 err=%b", l, ack, err, e);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_ack: busy=%b, required 1", busy);
        end
        tick();
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_ack: ack=%b busy=%b, required 0 and 0", ack, busy);
        end
    endtask

    task automatic test_readback(input int n);
        logic [7:0] exp;
        for (int i = 0; i <= n; i++) begin
            if (rd_q.size() > 0) begin
                exp = rd_q.pop_front();
                checks++;
                if (rd_data !== exp) begin
                    errors++;
                    $display("FAIL rd_data addr=%0d: got %0h, required %0h", i - 1, rd_data, exp);
                end
            end
            if (i < n) begin
                rd_addr = 9'(i);
                rd_q.push_back(exp_mem[i]);
            end
            tick();
        end
    endtask

    task automatic test_cold_miss();
        test_fill(32'd5, 1'b0, 512, 8'h5A, 1000);
        test_readback(512);
    endtask

    task automatic test_hit();
`ifdef SD_BUFFER_CACHE_EN
        logic e;
        exp_ack_q.push_back(1'b0);
        sd_rbusy = 1'b0;
        issue_req(32'd5, 1'b0);
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== 1'b1 || err !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_ack: ack=%b err=%b busy=%b, required 1 %b 0", ack, err, e, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0 || sd_rstart !== 1'b0) begin
                errors++;
                $display("FAIL hit_quiet: ack=%b busy=%b rstart=%b, required 0 0 0", ack, busy, sd_rstart);
            end
        end
`else
        test_fill(32'd5, 1'b0, 512, 8'h5A, 0);
`endif
        test_fill(32'd6, 1'b0, 512, 8'hA5, 0);
        test_readback(512);
    endtask

    task automatic test_flush();
        test_fill(32'd6, 1'b1, 512, 8'hC3, 0);
        test_readback(512);
    endtask

    task automatic test_short_sector();
        test_fill(32'd7, 1'b0, 300, 8'h11, 0);
        test_readback(300);
        test_fill(32'd7, 1'b0, 512, 8'h22, 0);
    endtask

    task automatic test_timeout();
        int   cnt;
        logic e;
        exp_ack_q.push_back(1'b1);
        sd_rbusy = 1'b0;
        issue_req(32'd8, 1'b0);
        cnt = 0;
        while (sd_rstart !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (sd_rstart !== 1'b1) begin
            errors++;
            $display("FAIL tmo_rstart: rstart=%b, required 1", sd_rstart);
        end
        sd_rbusy = 1'b1;
        cnt = 0;
        while (ack !== 1'b1 && cnt < 3000) begin
            tick();
            cnt++;
        end
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== 1'b1 || err !== e) begin
            errors++;
            $display("FAIL tmo_ack: ack=%b err=%b, required ack=1 err=%b", ack, err, e);
        end
        checks++;
        if (cnt < int'(TMO) || cnt > int'(TMO) + 1) begin
            errors++;
            $display("FAIL tmo_latency: ack %0d cycles after START, required %0d..%0d", cnt, TMO, TMO + 1);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_busy: busy=%b at ack, required 1", busy);
        end
        req = 1'b1;
        lba = 32'd99;
        tick();
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ack !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_hold: ack=%b busy=%b, required 0 and 1", ack, busy);
            end
            tick();
        end
        sd_rbusy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL drain_exit: ack=%b busy=%b, required 0 and 0", ack, busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_fill();
        int cnt;
        sd_rbusy = 1'b0;
        issue_req(32'd5, 1'b0);
        cnt = 0;
        while (sd_rstart !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        sd_rbusy = 1'b1;
        tick();
        stream(200, 8'h77);
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || sd_rstart !== 1'b0 ||
            sd_rsector !== 32'd0 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL midfill_reset: busy=%b ack=%b err=%b rstart=%b rsector=%0d rd_data=%0h, required all 0",
                     busy, ack, err, sd_rstart, sd_rsector, rd_data);
        end
        rst      = 1'b0;
        sd_rdone = 1'b1;
        sd_rbusy = 1'b0;
        tick();
        sd_rdone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_done: ack=%b busy=%b, required 0 and 0", ack, busy);
            end
            tick();
        end
        test_fill(32'd5, 1'b0, 512, 8'h99, 0);
        test_readback(64);
    endtask

    initial begin
        rst        = 1'b1;
        req        = 1'b0;
        lba        = '0;
        flush      = 1'b0;
        rd_addr    = '0;
        sd_rbusy   = 1'b0;
        sd_rdone   = 1'b0;
        sd_outen   = 1'b0;
        sd_outaddr = '0;
        sd_outbyte = '0;
        tick();

        test_reset();
        test_cold_miss();
        test_hit();
        test_flush();
        test_short_sector();
        test_timeout();
        test_reset_mid_fill();

        checks++;
        if (exp_ack_q.size() != 0) begin
            errors++;
            $display("FAIL ack_queue: %0d expected acks never seen, required 0", exp_ack_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_sector_buffer.md
# sd_sector_buffer

Client-side sector buffer sitting directly downstream of the SD-card sector reader. Accepts a sector request (LBA) from a disk/floppy controller, drives the reader's start/sector handshake, captures the 512 streamed bytes into an internal 512x8 RAM, and exposes them through a random-access read port. A single-entry tag skips the card access when the same LBA is requested again.

## Interface
- TIMEOUT_CYCLES, 32'd50_000_000: clk cycles from sd_rstart to sd_rdone before the fill is declared failed.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; one clock, synchronous, active-high.
- req  in  1  one-cycle request strobe; sampled only in IDLE.
- lba  in  32  sector number, sampled with req.
- flush  in  1  one-cycle strobe; clears the tag valid bit.
- busy  out  1  high while a card fill or drain is in progress.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid only with ack; 1 = fill failed.
- rd_addr  in  9  buffer byte address.
- rd_data  out  8  buffer byte, registered.
- sd_rstart  out  1  to reader rstart.
- sd_rsector  out  32  to reader rsector.
- sd_rbusy  in  1  reader busy (also high during card init).
- sd_rdone  in  1  reader one-cycle done.
- sd_outen, sd_outaddr[8:0], sd_outbyte[7:0]  in  reader byte stream.

## Operation
- States: IDLE, WAITRDY, START, FILL, DRAIN.
- IDLE: on req, latch lba into cur_lba. Hit (tag_valid && tag_lba==lba): no state change. Miss: clear tag_valid, go WAITRDY.
- WAITRDY: busy=1; wait for sd_rbusy==0, then START. Covers card initialisation after power-up.
- START: sd_rstart=1, sd_rsector=cur_lba; hold both until sd_rbusy==1, then FILL. Clear byte counter and timeout counter on START entry.
- FILL: every sd_outen writes sd_outbyte to RAM[sd_outaddr] and increments the 10-bit byte counter (saturating at 512). On sd_rdone: counter==512 → ack, err=0, tag_lba=cur_lba, tag_valid=1; counter≠512 → ack, err=1, tag_valid stays 0. Either way → IDLE.
- Timeout: counter runs in START and FILL; when it reaches TIMEOUT_CYCLES → ack, err=1, go DRAIN.
- DRAIN: busy=1; writes from sd_outen are still accepted but ignored for tag purposes; exit to IDLE on sd_rdone or sd_rbusy==0. No ack in DRAIN.
- The RAM has one write port (SD side) and one read port (client side), both active in every state. Reading during a fill returns mixed old/new data. Clients must wait for ack.
- flush: clears tag_valid in any state. If flush and req arrive in the same cycle in IDLE, flush applies first, so the request is a miss.
- req outside IDLE is ignored; it gets no ack and is not queued.

## Timing
- Reset values: busy=0, ack=0, err=0, sd_rstart=0, sd_rsector=0, rd_data=0, tag_valid=0, state=IDLE.
- rd_data is valid 1 cycle after rd_addr (registered RAM read).
- Hit: ack=1, err=0 in cycle N+1 for req in cycle N; busy stays 0.
- Miss: busy=1 from N+1 until the ack cycle inclusive; busy=0 the cycle after ack.
- sd_rstart rises no earlier than N+2 and is deasserted the cycle after sd_rbusy is sampled high.
- sd_outen writes are committed the same edge, so a read of that address 1 cycle later returns the new byte.
- Timeout counter is 32 bits; compare uses >= TIMEOUT_CYCLES.
- rst mid-fill returns the block to IDLE with the tag invalid. A later sd_rdone from the reader in IDLE is ignored.

## Configuration
- SD_BUFFER_CACHE_EN defined: tag compare and hit path are present as described.
- Not defined: tag logic is removed and every req is a miss. flush is accepted but has no effect.

## Test plan
- Cold miss: sd_rbusy=1 for 1000 cycles (init), then req lba=5 → sd_rstart held until sd_rbusy=1, sd_rsector=5; model streams bytes i^8'h5A → ack, err=0; rd_addr 0..511 returns i^8'h5A with 1-cycle latency.
- Hit (CACHE_EN): req lba=5 again → ack at N+1, busy never asserted, no sd_rstart. Then req lba=6 → full fill.
- Flush: flush and req lba=6 in the same cycle → miss; full card read with sd_rsector=6.
- Short sector: model sends 300 bytes then sd_rdone → ack with err=1. Next req of the same lba is a miss.
- Timeout: TIMEOUT_CYCLES=1000, model never asserts sd_rdone → ack+err at 1000 cycles after START; busy stays 1 until sd_rbusy falls, then back to IDLE.
- Reset mid-fill: rst at byte 200 → all outputs at reset values the next cycle; the trailing sd_rdone produces no ack; next req lba=5 is a miss.
